// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;
    localparam int RESET_PC_DEF = 32;
    localparam int PC_STEP_DEF  = 2;
    localparam int HWORD_BITS   = 16;
    localparam int INSTR_BITS   = 32;

    typedef logic [31:0] pc_t;
endpackage

// File: rtl/fetch_if.sv
// Core <-> fetch stage signal bundle. Optional stall input exists when FETCH_STALL_EN is defined.
interface fetch_if;
    import fetch_pkg::*;

    pc_t                   alu_out;
    logic                  pc_src;
`ifdef FETCH_STALL_EN
    logic                  stall;
`endif
    pc_t                   pc;
    logic [INSTR_BITS-1:0] instr;

`ifdef FETCH_STALL_EN
    modport master (output alu_out, output pc_src, output stall, input pc, input instr);
    modport slave  (input alu_out, input pc_src, input stall, output pc, output instr);
`else
    modport master (output alu_out, output pc_src, input pc, input instr);
    modport slave  (input alu_out, input pc_src, output pc, output instr);
`endif
endinterface

// File: rtl/pc_reg.sv
// Program counter register with redirect mux and wrapping incrementer.
// Optional hold input is compiled in when FETCH_STALL_EN is defined.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int RESET_PC = RESET_PC_DEF,
    parameter int PC_STEP  = PC_STEP_DEF
) (
    input  logic clk,
    input  logic reset,
    input  pc_t  alu_out,
    input  logic pc_src,
`ifdef FETCH_STALL_EN
    input  logic stall,
`endif
    output pc_t  pc
);
    pc_t pcReg;
    pc_t nextPc;

    // Redirect beats stall; the increment wraps modulo 2^32 by width.
    always_comb begin
        nextPc = pcReg + pc_t'(PC_STEP);
        if (pc_src) begin
            nextPc = alu_out;
        end
`ifdef FETCH_STALL_EN
        else if (stall) begin
            nextPc = pcReg;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcReg <= pc_t'(RESET_PC);
        end else begin
            pcReg <= nextPc;
        end
    end

    assign pc = pcReg;
endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC register plus bounds-checked 32-bit select from the flattened instruction memory.
// Define FETCH_STALL_EN to add the stall input.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int MEM_BITS = 16777216,
    parameter int RESET_PC = RESET_PC_DEF,
    parameter int PC_STEP  = PC_STEP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    // Leftmost bit is memory bit 0 (MSB of halfword 0), matching a [0:MEM_BITS-1] source positionally.
    input  logic [MEM_BITS-1:0] instr_mem,
    fetch_if.slave              bus
);
    localparam int IDX_W = $clog2(MEM_BITS);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(MEM_BITS - 1);

    pc_t              pcQ;
    logic [37:0]      bitOffset;
    logic [37:0]      lastBit;
    logic             inRange;
    logic [IDX_W-1:0] msbIdx;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .alu_out (bus.alu_out),
        .pc_src  (bus.pc_src),
`ifdef FETCH_STALL_EN
        .stall   (bus.stall),
`endif
        .pc      (pcQ)
    );

    // Wide offset so 16*pc never wraps back into the valid range.
    assign bitOffset = 38'(pcQ) * 38'(HWORD_BITS);
    assign lastBit   = bitOffset + 38'(INSTR_BITS - 1);
    assign inRange   = lastBit < 38'(MEM_BITS);
    assign msbIdx    = TOP_IDX - bitOffset[IDX_W-1:0];

    always_comb begin
        bus.instr = '0;
        if (inRange) begin
            bus.instr = instr_mem[msbIdx -: INSTR_BITS];
        end
    end

    assign bus.pc = pcQ;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a halfword-array reference model.
// Exercises the stall path too when FETCH_STALL_EN is defined.
module tb_fetch_stage;
    localparam int MEM_BITS = 4096;
    localparam int NHW      = MEM_BITS / 16;
    localparam logic [31:0] RST_PC = 32'd32;

    logic                clk = 1'b0;
    logic                reset;
    logic [MEM_BITS-1:0] instrMem;
    logic [15:0]         hw [0:NHW-1];
    logic [31:0]         modelPc;
    logic                stallVal;
    logic                checkEn = 1'b0;
    int                  total = 0;
    int                  bad = 0;

    fetch_if bus ();

    fetch_stage #(.MEM_BITS(MEM_BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr_mem (instrMem),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Instruction at halfword p: two consecutive halfwords, zero if any bit lies past the memory.
    function automatic logic [31:0] modelInstr(logic [31:0] p);
        longint lastBitIdx;
        lastBitIdx = longint'(p) * 16 + 31;
        if (lastBitIdx >= MEM_BITS) return 32'h0;
        return {hw[int'(p)], hw[int'(p) + 1]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            chk("pc_cycle", bus.pc, modelPc);
            chk("instr_cycle", bus.instr, modelInstr(modelPc));
        end
    end

    task automatic tick();
        @(posedge clk);
        if (reset)            modelPc = RST_PC;
        else if (bus.pc_src)  modelPc = bus.alu_out;
        else if (!stallVal)   modelPc = modelPc + 32'd2;
        #1;
        $display("t=%0t reset=%0b pc_src=%0b alu_out=%h stall=%0b -> pc=%h instr=%h",
                 $time, reset, bus.pc_src, bus.alu_out, stallVal, bus.pc, bus.instr);
    endtask

    task automatic setStall(logic s);
        stallVal = s;
`ifdef FETCH_STALL_EN
        bus.stall = s;
`endif
    endtask

    task automatic redirect(logic [31:0] target);
        bus.pc_src  = 1'b1;
        bus.alu_out = target;
        tick();
        bus.pc_src  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NHW; i++) hw[i] = 16'(i * 257) ^ 16'h5a3c;
        hw[32] = 16'h0000; hw[33] = 16'h0042;
        hw[34] = 16'h0000; hw[35] = 16'h0046;
        for (int i = 0; i < NHW; i++) instrMem[MEM_BITS - 1 - 16 * i -: 16] = hw[i];

        reset = 1'b1;
        bus.pc_src = 1'b0;
        bus.alu_out = 32'h0;
        setStall(1'b0);
        modelPc = RST_PC;
        #2;
        chk("reset_pc", bus.pc, 32'd32);
        chk("reset_instr", bus.instr, 32'h0000_0042);
        tick();
        tick();
        chk("reset_held_pc", bus.pc, 32'd32);
        checkEn = 1'b1;

        // Release between edges; first advance happens on the following edge.
        reset = 1'b0;
        tick();
        chk("seq1_pc", bus.pc, 32'd34);
        chk("seq1_instr", bus.instr, 32'h0000_0046);
        tick();
        chk("seq2_pc", bus.pc, 32'd36);

        redirect(32'd32);
        chk("redir_pc", bus.pc, 32'd32);
        tick();
        chk("after_redir_pc", bus.pc, 32'd34);
        tick();
        chk("pre_async_pc", bus.pc, 32'd36);

        // Mid-cycle asynchronous reset.
        #2;
        reset = 1'b1;
        modelPc = RST_PC;
        #1;
        chk("async_reset_pc", bus.pc, 32'd32);
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_pc", bus.pc, 32'd34);

        redirect(32'hFFFF_FFFE);
        chk("wrap_pc", bus.pc, 32'hFFFF_FFFE);
        chk("wrap_instr", bus.instr, 32'h0);
        tick();
        chk("wrapped_pc", bus.pc, 32'h0);
        chk("pc0_instr", bus.instr, 32'h5a3c_5b3d);

        redirect(32'h1000_0000);
        chk("huge_pc_instr", bus.instr, 32'h0);
        redirect(32'd254);
        chk("last_word_instr", bus.instr, {hw[254], hw[255]});
        tick();
        chk("past_end_pc", bus.pc, 32'd256);
        redirect(32'd255);
        chk("straddle_end_instr", bus.instr, 32'h0);
        redirect(32'd33);
        chk("odd_pc_instr", bus.instr, 32'h0042_0000);
        tick();
        chk("odd_seq_pc", bus.pc, 32'd35);

`ifdef FETCH_STALL_EN
        setStall(1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_hold_pc", bus.pc, 32'd35);
        end
        redirect(32'd40);
        chk("stall_redir_pc", bus.pc, 32'd40);
        setStall(1'b0);
        tick();
        chk("unstall_pc", bus.pc, 32'd42);
`endif

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
